// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the parametrised SPI master.
//   state_t       : controller states IDLE -> SETUP -> XFER -> HOLD
//   MODE0..MODE3  : SPI mode encodings as {cpol, cpha}
//   cnt_w()       : width of a counter that must hold values 0..max_val
// ---------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Bits needed to count from 0 up to and including max_val (at least 1).
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/spi_master_param_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen
// Registered SCLK divider. While enable is low SCLK rests at cpol and both
// counters are held at zero. While enable is high SCLK toggles every CLK_DIV
// sys_clk cycles.
//
// The edge strobes are combinational look-aheads: they are high in the cycle
// *before* the sys_clk edge that launches the SCLK edge, so the controller can
// shift MOSI / sample MISO on exactly the same sys_clk edge that moves SCLK.
//
// Ports:
//   sys_clk, rst_n : clock, synchronous active-low reset
//   enable         : run the divider (controller is in XFER)
//   cpol           : idle level of SCLK
//   spi_sclk       : registered serial clock
//   lead_edge      : next launched SCLK edge is a leading (odd-numbered) edge
//   trail_edge     : next launched SCLK edge is a trailing (even-numbered) edge
//   last_edge      : next launched SCLK edge is the final edge of the frame
// ---------------------------------------------------------------------------
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int N_EDGES = 48
)(
   input  logic sys_clk,
   input  logic rst_n,
   input  logic enable,
   input  logic cpol,
   output logic spi_sclk,
   output logic lead_edge,
   output logic trail_edge,
   output logic last_edge
);

   localparam int DIV_W  = cnt_w(CLK_DIV);
   localparam int EDGE_W = cnt_w(N_EDGES);

   logic [DIV_W-1:0]  div_cnt;
   logic [EDGE_W-1:0] edge_cnt;
   logic              tick;

   assign tick       = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
   // edge_cnt holds the number of edges already launched, so an even count
   // means the upcoming edge is odd-numbered, i.e. leading.
   assign lead_edge  = tick && !edge_cnt[0];
   assign trail_edge = tick &&  edge_cnt[0];
   assign last_edge  = tick && (edge_cnt == EDGE_W'(N_EDGES - 1));

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         spi_sclk <= 1'b0;
         div_cnt  <= '0;
         edge_cnt <= '0;
      end else if (!enable) begin
         spi_sclk <= cpol;
         div_cnt  <= '0;
         edge_cnt <= '0;
      end else if (tick) begin
         spi_sclk <= ~spi_sclk;
         div_cnt  <= '0;
         edge_cnt <= edge_cnt + EDGE_W'(1);
      end else begin
         div_cnt  <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_master_param.sv
// ---------------------------------------------------------------------------
// spi_master_param
// Parametrised SPI master (MSB first) for ADC/DAC peripherals.
//
// Parameters: DATA_W (bits/frame), CLK_DIV (sys_clk cycles per SCLK half
// period), CS_SETUP, CS_HOLD (sys_clk cycles around the SCLK burst).
//
// Optional build macro SPI_LOOPBACK_EN: adds the loopback input; when it is
// high the receive path takes spi_mosi instead of spi_miso.
//
// Ports:
//   sys_clk, rst_n  : clock, synchronous active-low reset
//   cpol, cpha      : SPI mode, captured when start is accepted
//   start, tx_data  : transfer request and word to send
//   busy, done      : busy while a frame runs, one-cycle done at frame end
//   rx_data         : received word, updated in the done cycle
//   spi_sclk/mosi/miso/cs_n : SPI pins
//   fsm_state       : current controller state (state_t encoding)
//
// Handshake: start is honoured only in a cycle where busy=0 (controller in
// IDLE); it is then accepted on that sys_clk edge, busy rises and CS_n falls
// in the next cycle. A start while busy=1 is dropped, never queued. done is
// high for exactly one cycle, together with busy falling, so a start held
// high in the done cycle launches the next frame immediately.
//
// Timeline from the accept edge: one cycle for CS_n to go low, CS_SETUP
// further cycles of setup, 2*DATA_W*CLK_DIV cycles of SCLK, then CS_HOLD
// cycles before done: 1 + CS_SETUP + 2*DATA_W*CLK_DIV + CS_HOLD in total.
// ---------------------------------------------------------------------------
module spi_master_param
   import spi_pkg::*;
#(
   parameter int DATA_W   = 24,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
)(
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LOOPBACK_EN
   input  logic              loopback,
`endif
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              spi_cs_n,
   output logic [1:0]        fsm_state
);

   localparam int N_EDGES = 2 * DATA_W;
   localparam int PH_W    = cnt_w((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);

   state_t            state;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [PH_W-1:0]   phase_cnt;
   logic              cpol_q;
   logic              cpha_q;
   logic              sclk_idle;
   logic              miso_src;
   logic              lead_edge;
   logic              trail_edge;
   logic              last_edge;

   assign fsm_state = state;

`ifdef SPI_LOOPBACK_EN
   assign miso_src = loopback ? spi_mosi : spi_miso;
`else
   assign miso_src = spi_miso;
`endif

   // Use the incoming cpol on the accept edge so SCLK already sits at the
   // new idle level in the first SETUP cycle.
   assign sclk_idle = (state == IDLE && start) ? cpol : cpol_q;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV),
      .N_EDGES (N_EDGES)
   ) u_clk_gen (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .enable     (state == XFER),
      .cpol       (sclk_idle),
      .spi_sclk   (spi_sclk),
      .lead_edge  (lead_edge),
      .trail_edge (trail_edge),
      .last_edge  (last_edge)
   );

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rx_data   <= '0;
         spi_cs_n  <= 1'b1;
         spi_mosi  <= 1'b0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         phase_cnt <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cpol_q    <= cpol;
                  cpha_q    <= cpha;
                  rx_sr     <= '0;
                  phase_cnt <= '0;
                  busy      <= 1'b1;
                  spi_cs_n  <= 1'b0;
                  state     <= SETUP;
                  // cpha=0 presents the MSB before the first (sampling) edge;
                  // cpha=1 puts it out on the first leading edge instead.
                  if (cpha) begin
                     tx_sr <= tx_data;
                  end else begin
                     spi_mosi <= tx_data[DATA_W-1];
                     tx_sr    <= {tx_data[DATA_W-2:0], 1'b0};
                  end
               end
            end

            SETUP: begin
               if (phase_cnt == PH_W'(CS_SETUP)) begin
                  phase_cnt <= '0;
                  state     <= XFER;
               end else begin
                  phase_cnt <= phase_cnt + PH_W'(1);
               end
            end

            XFER: begin
               // Strobes are look-aheads, so these updates land on the same
               // sys_clk edge that moves SCLK; MISO is taken as seen there.
               if (lead_edge) begin
                  if (cpha_q) begin
                     spi_mosi <= tx_sr[DATA_W-1];
                     tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
                  end else begin
                     rx_sr <= {rx_sr[DATA_W-2:0], miso_src};
                  end
               end
               if (trail_edge) begin
                  if (cpha_q) begin
                     rx_sr <= {rx_sr[DATA_W-2:0], miso_src};
                  end else if (!last_edge) begin
                     spi_mosi <= tx_sr[DATA_W-1];
                     tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
                  end
               end
               if (last_edge) begin
                  phase_cnt <= '0;
                  state     <= HOLD;
               end
            end

            HOLD: begin
               if (phase_cnt == PH_W'(CS_HOLD - 1)) begin
                  phase_cnt <= '0;
                  spi_cs_n  <= 1'b1;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  rx_data   <= rx_sr;
                  state     <= IDLE;
               end else begin
                  phase_cnt <= phase_cnt + PH_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_param.sv
// ---------------------------------------------------------------------------
// tb_spi_master_param
// Bench for spi_master_param with default parameters. A behavioural SPI
// slave answers each frame with a chosen word and records what it saw on
// MOSI; expectations are queued when a start is accepted and checked when
// done appears.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_param;
   import spi_pkg::*;

   localparam int DATA_W   = 24;
   localparam int CLK_DIV  = 4;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int N_EDGES  = 2 * DATA_W;
   localparam int LAT      = 1 + CS_SETUP + 2 * DATA_W * CLK_DIV + CS_HOLD;

   // ---------------- clock / reset ----------------
   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic              cpol = 1'b0;
   logic              cpha = 1'b0;
   logic              start = 1'b0;
   logic [DATA_W-1:0] tx_data = '0;
   logic              spi_miso = 1'b0;
   logic              busy, done, spi_sclk, spi_mosi, spi_cs_n;
   logic [DATA_W-1:0] rx_data;
   logic [1:0]        fsm_state;
`ifdef SPI_LOOPBACK_EN
   logic              lb_off = 1'b0;
`endif

   spi_master_param #(
      .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
   ) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .cpol      (cpol),
      .cpha      (cpha),
      .start     (start),
      .tx_data   (tx_data),
`ifdef SPI_LOOPBACK_EN
      .loopback  (lb_off),
`endif
      .busy      (busy),
      .done      (done),
      .rx_data   (rx_data),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .spi_cs_n  (spi_cs_n),
      .fsm_state (fsm_state)
   );

   // ---------------- scoreboard state ----------------
   int                total = 0;
   int                bad = 0;
   int                done_cnt = 0;
   int                exp_frames = 0;
   logic [DATA_W-1:0] exp_rx_q[$];
   logic [DATA_W-1:0] exp_tx_q[$];
   int                exp_cyc_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flush_exp();
      exp_frames -= exp_rx_q.size();
      exp_rx_q.delete();
      exp_tx_q.delete();
      exp_cyc_q.delete();
   endtask

   // ---------------- slave model ----------------
   // Mode rules: leading edges are odd-numbered. The slave samples MOSI on
   // the edge selected by cpha and changes MISO on the other one; with
   // cpha=0 the MSB is presented as soon as CS_n falls.
   logic              cur_cpol = 1'b0;
   logic              cur_cpha = 1'b0;
   logic [DATA_W-1:0] slave_word = '0;
   logic [DATA_W-1:0] mosi_cap = '0;
   int                edge_n = 0;
   logic              prev_cs = 1'b1;
   logic              prev_sclk = 1'b0;
   logic              idle_err = 1'b0;

   initial begin : slave_model
      int   idx;
      logic lead;
      forever begin
         @(negedge sys_clk);
         if (!rst_n) begin
            edge_n = 0;
         end else if (prev_cs && !spi_cs_n) begin
            edge_n   = 0;
            mosi_cap = '0;
            idle_err = 1'b0;
            if (spi_sclk !== cur_cpol) idle_err = 1'b1;
            if (!cur_cpha) spi_miso = slave_word[DATA_W-1];
         end else if (!spi_cs_n) begin
            if (spi_sclk !== prev_sclk) begin
               edge_n++;
               lead = (edge_n % 2) == 1;
               if (lead ^ cur_cpha) begin
                  mosi_cap = {mosi_cap[DATA_W-2:0], spi_mosi};
               end else begin
                  idx = cur_cpha ? DATA_W - (edge_n + 1) / 2 : DATA_W - 1 - edge_n / 2;
                  if (idx >= 0 && idx < DATA_W) spi_miso = slave_word[idx];
               end
            end else if ((edge_n == 0 || edge_n == N_EDGES) && spi_sclk !== cur_cpol) begin
               idle_err = 1'b1;
            end
         end
         prev_cs   = spi_cs_n;
         prev_sclk = spi_sclk;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge sys_clk) begin
      if (rst_n && done) begin
         done_cnt++;
         if (exp_rx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done with no frame pending (cycle %0d)", cyc);
         end else begin
            chk("rx_data",      rx_data,  exp_rx_q.pop_front());
            chk("mosi_word",    mosi_cap, exp_tx_q.pop_front());
            chk("done_latency", cyc,      exp_cyc_q.pop_front());
            chk("sclk_edges",   edge_n,   N_EDGES);
            chk("sclk_idle",    idle_err, 0);
            chk("cs_n_at_done", spi_cs_n, 1);
            chk("busy_at_done", busy,     0);
         end
      end
   end

   // ---------------- drivers ----------------
   // Called at a negedge while the DUT is idle; returns just after the
   // accept edge with the expectation queued.
   task automatic launch(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] sw,
                         input logic [1:0] mode);
      cur_cpol   = mode[1];
      cur_cpha   = mode[0];
      slave_word = sw;
      cpol       = mode[1];
      cpha       = mode[0];
      tx_data    = tx;
      start      = 1'b1;
      @(posedge sys_clk);
      #1;
      exp_rx_q.push_back(sw);
      exp_tx_q.push_back(tx);
      exp_cyc_q.push_back(cyc + LAT);
      exp_frames++;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 3 * LAT && (busy || exp_rx_q.size() > 0); i++) @(negedge sys_clk);
      if (busy || exp_rx_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL timeout_%s: busy=%0d pending=%0d", name, busy, exp_rx_q.size());
         flush_exp();
      end
      @(negedge sys_clk);
   endtask

   // ---------------- optional loopback instance ----------------
`ifdef SPI_LOOPBACK_EN
   logic       lb_start = 1'b0;
   logic [7:0] lb_tx = 8'h81;
   logic       lb_busy, lb_done, lb_sclk, lb_mosi, lb_cs_n;
   logic [7:0] lb_rx;
   logic [1:0] lb_state;

   spi_master_param #(.DATA_W(8), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) lb_dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .cpol      (1'b0),
      .cpha      (1'b0),
      .start     (lb_start),
      .tx_data   (lb_tx),
      .loopback  (1'b1),
      .busy      (lb_busy),
      .done      (lb_done),
      .rx_data   (lb_rx),
      .spi_sclk  (lb_sclk),
      .spi_mosi  (lb_mosi),
      .spi_miso  (1'b0),
      .spi_cs_n  (lb_cs_n),
      .fsm_state (lb_state)
   );
`endif

   // ---------------- watchdog ----------------
   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [1:0]        modes [4];
      logic [DATA_W-1:0] r_tx, r_sw;
      int                acc;
      modes = '{MODE0, MODE1, MODE2, MODE3};

      rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("rst_busy",  busy,      0);
      chk("rst_done",  done,      0);
      chk("rst_rx",    rx_data,   0);
      chk("rst_cs_n",  spi_cs_n,  1);
      chk("rst_sclk",  spi_sclk,  0);
      chk("rst_mosi",  spi_mosi,  0);
      chk("rst_state", fsm_state, 64'(IDLE));
      rst_n = 1'b1;
      @(negedge sys_clk);

      // All four modes with the same words.
      for (int m = 0; m < 4; m++) begin
         launch(24'hA5C33C, 24'h123456, modes[m]);
         @(negedge sys_clk);
         chk("busy_after_accept", busy, 1);
         chk("cs_low_after_accept", spi_cs_n, 0);
         wait_idle("mode");
         chk("sclk_idle_after_frame", spi_sclk, modes[m][1]);
      end

      // Start while busy is dropped.
      launch(24'hA5C33C, 24'h654321, MODE0);
      repeat (60) @(negedge sys_clk);
      tx_data = 24'hFFFFFF;
      start   = 1'b1;
      @(negedge sys_clk);
      start   = 1'b0;
      wait_idle("ignored_start");
      repeat (LAT + 10) @(negedge sys_clk);
      chk("no_queued_frame", done_cnt, exp_frames);

      // Back-to-back with start held high.
      cur_cpol = 1'b1; cur_cpha = 1'b0; cpol = 1'b1; cpha = 1'b0;
      slave_word = 24'h0F0F0F;
      tx_data = 24'h3C3C3C;
      start = 1'b1;
      @(posedge sys_clk);
      #1;
      exp_rx_q.push_back(24'h0F0F0F);
      exp_tx_q.push_back(24'h3C3C3C);
      exp_cyc_q.push_back(cyc + LAT);
      exp_frames++;
      tx_data = 24'hC0FFEE;
      for (int i = 0; i < 2 * LAT && !done; i++) @(negedge sys_clk);
      chk("b2b_first_done", done, 1);
      if (done) begin
         slave_word = 24'hBEEF01;
         exp_rx_q.push_back(24'hBEEF01);
         exp_tx_q.push_back(24'hC0FFEE);
         exp_cyc_q.push_back(cyc + 1 + LAT);
         exp_frames++;
         chk("b2b_cs_gap_high", spi_cs_n, 1);
         @(negedge sys_clk);
         chk("b2b_cs_low_again", spi_cs_n, 0);
         chk("b2b_busy_again", busy, 1);
      end
      start = 1'b0;
      wait_idle("b2b");

      // Reset in the middle of XFER.
      launch(24'h5A5A5A, 24'hA1B2C3, MODE3);
      for (int i = 0; i < 2 * LAT && edge_n < 10; i++) @(negedge sys_clk);
      chk("reached_edge_10", edge_n >= 10, 1);
      rst_n = 1'b0;
      @(posedge sys_clk);
      #1;
      flush_exp();
      chk("abort_cs_n",  spi_cs_n,  1);
      chk("abort_busy",  busy,      0);
      chk("abort_sclk",  spi_sclk,  0);
      chk("abort_done",  done,      0);
      chk("abort_state", fsm_state, 64'(IDLE));
      @(negedge sys_clk);
      rst_n = 1'b1;
      @(negedge sys_clk);
      launch(24'h13579B, 24'h2468AC, MODE1);
      wait_idle("after_reset");

      // Randomised frames.
      for (int n = 0; n < 6; n++) begin
         r_tx = DATA_W'($urandom);
         r_sw = DATA_W'($urandom);
         launch(r_tx, r_sw, 2'($urandom_range(0, 3)));
         wait_idle("random");
      end

`ifdef SPI_LOOPBACK_EN
      lb_start = 1'b1;
      @(posedge sys_clk);
      #1;
      acc = cyc;
      lb_start = 1'b0;
      for (int i = 0; i < 100 && !lb_done; i++) @(negedge sys_clk);
      chk("lb_done_seen", lb_done, 1);
      chk("lb_rx", lb_rx, 8'h81);
      chk("lb_latency", cyc - acc, 21);
`else
      acc = 0;
`endif

      repeat (5) @(negedge sys_clk);
      chk("done_count", done_cnt, exp_frames + acc * 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
